// File: rtl/branch_tag_allocator_if.sv
// Decode-side handshake and status bundle for the branch tag allocator.
// The master drives requests, releases and flushes; the slave returns grants, tags and occupancy.
interface branch_tag_allocator_if #(
   parameter int MAX_BRANCH_IF = 4,
   parameter int TAG_BITS      = $clog2(MAX_BRANCH_IF)
);
   logic                     alloc_req_1;
   logic                     alloc_req_2;
   logic                     alloc_fire;
   logic                     alloc_gnt_1;
   logic                     alloc_gnt_2;
   logic [TAG_BITS-1:0]      alloc_tag_1;
   logic [TAG_BITS-1:0]      alloc_tag_2;
   logic                     stall_o;
   logic                     release_valid;
   logic [TAG_BITS-1:0]      release_tag;
   logic                     flush_valid;
   logic [TAG_BITS-1:0]      flush_tag;
   logic [MAX_BRANCH_IF-1:0] busy_mask_o;
   logic [MAX_BRANCH_IF-1:0] dep_mask_o;
   logic [TAG_BITS:0]        busy_count_o;

   modport master (
      output alloc_req_1, alloc_req_2, alloc_fire,
      output release_valid, release_tag, flush_valid, flush_tag,
      input  alloc_gnt_1, alloc_gnt_2, alloc_tag_1, alloc_tag_2, stall_o,
      input  busy_mask_o, dep_mask_o, busy_count_o
   );

   modport slave (
      input  alloc_req_1, alloc_req_2, alloc_fire,
      input  release_valid, release_tag, flush_valid, flush_tag,
      output alloc_gnt_1, alloc_gnt_2, alloc_tag_1, alloc_tag_2, stall_o,
      output busy_mask_o, dep_mask_o, busy_count_o
   );
endinterface

// File: rtl/branch_tag_allocator.sv
// Branch tag (checkpoint id) allocator: two decode slots per cycle, per-tag
// dependency rows so a mispredict squashes the branch and everything younger.
module branch_tag_allocator #(
   parameter int MAX_BRANCH_IF = 4,
   parameter int TAG_BITS      = $clog2(MAX_BRANCH_IF)
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_tag_allocator_if.slave bus
);
   localparam int N  = MAX_BRANCH_IF;
   localparam int CW = TAG_BITS + 1;

   logic [N-1:0]          busy;
   logic [N-1:0][N-1:0]   dep;
   logic [N-1:0]          busy_n;
   logic [N-1:0][N-1:0]   dep_n;

   logic [CW-1:0]         busy_cnt;
   logic [CW-1:0]         free_cnt;
   logic [CW-1:0]         need;
   logic [TAG_BITS-1:0]   free_lo;
   logic [TAG_BITS-1:0]   free_nx;
   logic                  found_lo;
   logic                  found_nx;
   logic                  stall;
   logic                  grant_ok;
   logic                  gnt_1;
   logic                  gnt_2;
   logic [TAG_BITS-1:0]   tag_1;
   logic [TAG_BITS-1:0]   tag_2;

   logic                  flush_hit;
   logic                  rel_hit;
   logic [N-1:0]          kill;
   logic [N-1:0]          rel_clr;
   logic [N-1:0]          rel_apply;
   logic [N-1:0]          busy_post_rel;

   always_comb begin
      free_lo  = '0;
      free_nx  = '0;
      found_lo = 1'b0;
      found_nx = 1'b0;
      busy_cnt = '0;
      for (int i = 0; i < N; i++) begin
         busy_cnt = busy_cnt + CW'(busy[i]);
         if (!busy[i]) begin
            if (!found_lo) begin
               free_lo  = TAG_BITS'(i);
               found_lo = 1'b1;
            end else if (!found_nx) begin
               free_nx  = TAG_BITS'(i);
               found_nx = 1'b1;
            end
         end
      end
   end

   // Free count comes from the registered bitmap only, so a tag released
   // this cycle cannot be handed out until the next one.
   assign need     = CW'(bus.alloc_req_1) + CW'(bus.alloc_req_2);
   assign free_cnt = CW'(N) - busy_cnt;
   assign stall    = (need > free_cnt) & ~bus.flush_valid;
   assign grant_ok = ~stall & ~bus.flush_valid;
   assign gnt_1    = bus.alloc_req_1 & grant_ok;
   assign gnt_2    = bus.alloc_req_2 & grant_ok;
   assign tag_1    = free_lo;
   assign tag_2    = bus.alloc_req_1 ? free_nx : free_lo;

   assign flush_hit = bus.flush_valid & busy[bus.flush_tag];
   assign rel_hit   = bus.release_valid & busy[bus.release_tag];

   always_comb begin
      kill = '0;
      if (flush_hit) begin
         for (int i = 0; i < N; i++) begin
            kill[i] = busy[i] & dep[i][bus.flush_tag];
         end
         kill[bus.flush_tag] = 1'b1;
      end
   end

   assign rel_clr       = rel_hit ? (N'(1) << bus.release_tag) : '0;
   assign rel_apply     = rel_clr & ~kill;
   assign busy_post_rel = busy & ~rel_clr;

   // Grants imply no flush, so kill is empty whenever a new row is written.
   always_comb begin
      busy_n = busy & ~kill & ~rel_apply;
      for (int i = 0; i < N; i++) begin
         dep_n[i] = kill[i] ? '0 : (dep[i] & ~kill & ~rel_apply);
      end
      if (bus.alloc_fire && gnt_1) begin
         busy_n[tag_1] = 1'b1;
         dep_n[tag_1]  = busy_post_rel;
      end
      if (bus.alloc_fire && gnt_2) begin
         busy_n[tag_2] = 1'b1;
         dep_n[tag_2]  = busy_post_rel | (gnt_1 ? (N'(1) << tag_1) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         dep  <= '0;
      end else begin
         busy <= busy_n;
         dep  <= dep_n;
      end
   end

   assign bus.alloc_gnt_1  = gnt_1;
   assign bus.alloc_gnt_2  = gnt_2;
   assign bus.alloc_tag_1  = tag_1;
   assign bus.alloc_tag_2  = tag_2;
   assign bus.stall_o      = stall;
   assign bus.busy_mask_o  = busy;
   assign bus.dep_mask_o   = busy_post_rel;
   assign bus.busy_count_o = busy_cnt;
endmodule

// File: tb/tb_branch_tag_allocator.sv
// Bench for branch_tag_allocator: directed scenarios plus random traffic,
// checked against an age-ordered model (tag allocation sequence numbers).
module tb_branch_tag_allocator;
   localparam int N  = 4;
   localparam int TB = 2;

   logic clk;
   logic rst_n;

   branch_tag_allocator_if #(.MAX_BRANCH_IF(N), .TAG_BITS(TB)) bus ();

   branch_tag_allocator #(.MAX_BRANCH_IF(N), .TAG_BITS(TB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   // Model: a live tag carries the sequence number of its allocation; younger = larger.
   bit          live [N];
   int unsigned seq  [N];
   int unsigned ctr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] live_mask();
      logic [31:0] m = '0;
      for (int i = 0; i < N; i++) if (live[i]) m[i] = 1'b1;
      return m;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         live[i] = 1'b0;
         seq[i]  = 0;
      end
      ctr = 0;
   endtask

   task automatic step(input int r1, input int r2, input int fire,
                       input int rv, input int rt, input int fv, input int ft);
      int    fl[$];
      int    need, t1, t2, cnt;
      bit    e_stall, ok, g1, g2;
      bit    kill [N];
      logic [31:0] dm;
      bus.alloc_req_1   = r1[0];
      bus.alloc_req_2   = r2[0];
      bus.alloc_fire    = fire[0];
      bus.release_valid = rv[0];
      bus.release_tag   = TB'(rt);
      bus.flush_valid   = fv[0];
      bus.flush_tag     = TB'(ft);
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (!live[i]) fl.push_back(i);
         else cnt++;
      end
      need    = r1 + r2;
      e_stall = (need > fl.size()) && (fv == 0);
      ok      = !e_stall && (fv == 0);
      g1      = (r1 != 0) && ok;
      g2      = (r2 != 0) && ok;
      t1      = (fl.size() > 0) ? fl[0] : 0;
      t2      = (r1 != 0) ? ((fl.size() > 1) ? fl[1] : 0) : t1;
      dm      = live_mask();
      if (rv != 0 && live[rt]) dm[rt] = 1'b0;
      chk("stall", 32'(bus.stall_o), 32'(e_stall));
      chk("gnt_1", 32'(bus.alloc_gnt_1), 32'(g1));
      chk("gnt_2", 32'(bus.alloc_gnt_2), 32'(g2));
      chk("busy_mask", 32'(bus.busy_mask_o), live_mask());
      chk("busy_count", 32'(bus.busy_count_o), 32'(cnt));
      if (g1) begin
         chk("tag_1", 32'(bus.alloc_tag_1), 32'(t1));
         chk("dep_mask", 32'(bus.dep_mask_o), dm);
      end
      if (g2) chk("tag_2", 32'(bus.alloc_tag_2), 32'(t2));
      // advance the model to the post-edge state
      for (int i = 0; i < N; i++) kill[i] = 1'b0;
      if (fv != 0 && live[ft]) begin
         for (int i = 0; i < N; i++) kill[i] = live[i] && (seq[i] >= seq[ft]);
      end
      if (rv != 0 && live[rt] && !kill[rt]) live[rt] = 1'b0;
      for (int i = 0; i < N; i++) if (kill[i]) live[i] = 1'b0;
      if (fire != 0 && g1) begin live[t1] = 1'b1; seq[t1] = ctr; ctr++; end
      if (fire != 0 && g2) begin live[t2] = 1'b1; seq[t2] = ctr; ctr++; end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic mid_reset();
      bus.alloc_req_1   = 1'b0;
      bus.alloc_req_2   = 1'b0;
      bus.alloc_fire    = 1'b0;
      bus.release_valid = 1'b0;
      bus.flush_valid   = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy_mask_o), 32'h0);
      chk("rst_count", 32'(bus.busy_count_o), 32'h0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      model_clear();
      rst_n             = 1'b0;
      bus.alloc_req_1   = 1'b0;
      bus.alloc_req_2   = 1'b0;
      bus.alloc_fire    = 1'b0;
      bus.release_valid = 1'b0;
      bus.release_tag   = '0;
      bus.flush_valid   = 1'b0;
      bus.flush_tag     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset state, then first pair of tags
      idle();
      step(1, 1, 1, 0, 0, 0, 0);
      chk("pair_busy", 32'(bus.busy_mask_o), 32'h3);
      chk("pair_count", 32'(bus.busy_count_o), 32'd2);

      // three live, two requested: stall; release 1 then reuse
      step(1, 0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      chk("rel1_busy", 32'(bus.busy_mask_o), 32'h5);
      step(1, 1, 1, 0, 0, 0, 0);
      chk("full_busy", 32'(bus.busy_mask_o), 32'hF);
      step(1, 0, 1, 0, 0, 0, 0);

      // squash everything from the oldest, then in-order alloc and flush 1
      step(0, 0, 0, 0, 0, 1, 0);
      chk("flush_all", 32'(bus.busy_mask_o), 32'h0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("flush1_busy", 32'(bus.busy_mask_o), 32'h1);
      chk("flush1_count", 32'(bus.busy_count_o), 32'd1);

      // flush together with alloc: no grant, flush only
      step(1, 1, 1, 0, 0, 1, 0);
      chk("flush_alloc", 32'(bus.busy_mask_o), 32'h0);

      // release 0 with flush 1; then release of a non-busy tag
      step(1, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1, 1);
      chk("relflush", 32'(bus.busy_mask_o), 32'h0);
      step(0, 0, 0, 1, 2, 0, 0);
      chk("rel_nonbusy", 32'(bus.busy_mask_o), 32'h0);

      // out-of-order release then flush of the middle tag
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("ooo_rel", 32'(bus.busy_mask_o), 32'h6);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("ooo_flush", 32'(bus.busy_mask_o), 32'h0);

      // release and alloc in the same cycle
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);

      mid_reset();

      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 199) == 0) mid_reset();
         else step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 9) == 0), int'($urandom_range(0, N - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
